simon_seq_ctrl: RTL

Game sequencer for the Simon datapath. It appends one random colour per round to the 64-entry x 4-bit sequence memory, plays the stored sequence back on the LEDs at tick-paced timing, and checks player button presses against memory. It sits between the LFSR/tick generators, the button debouncer and the sequence memory. It owns the memory's write port and read address.

---
 rtl/simon_seq_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/simon_seq_ctrl.sv
// Simon game sequencer: grows the colour sequence one entry per round, plays it back
// on the LEDs at tick-paced timing and checks the player's presses against memory.
module simon_seq_ctrl #(
    parameter int N_ELEMENTS    = 64,
    parameter int ADDR_WIDTH    = 6,
    parameter int DATA_WIDTH    = 4,
    parameter int ON_TICKS      = 4,
    parameter int OFF_TICKS     = 2,
    parameter int TIMEOUT_TICKS = 40
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  tick,
    input  logic [1:0]            rnd,
    input  logic                  btn_valid,
    input  logic [DATA_WIDTH-1:0] btn,
    output logic [ADDR_WIDTH-1:0] mem_r_addr,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    output logic [ADDR_WIDTH-1:0] mem_w_addr,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    output logic                  mem_w_en,
    output logic [DATA_WIDTH-1:0] led,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  busy,
    output logic                  await_input,
    output logic                  game_over,
    output logic                  win
);

    localparam int MAX_T = (TIMEOUT_TICKS > ON_TICKS)
                         ? ((TIMEOUT_TICKS > OFF_TICKS) ? TIMEOUT_TICKS : OFF_TICKS)
                         : ((ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS);
    localparam int CW = $clog2(MAX_T + 1);
    localparam int LW = ADDR_WIDTH + 1;

    localparam logic [CW-1:0]         ON_LAST  = CW'(ON_TICKS - 1);
    localparam logic [CW-1:0]         OFF_LAST = CW'(OFF_TICKS - 1);
    localparam logic [CW-1:0]         TO_LAST  = CW'(TIMEOUT_TICKS - 1);
    localparam logic [CW-1:0]         ONE_C    = 1;
    localparam logic [ADDR_WIDTH-1:0] ONE_A    = 1;
    localparam logic [LW-1:0]         ONE_L    = 1;
    localparam logic [LW-1:0]         LVL_MAX  = LW'(N_ELEMENTS);
    localparam logic [DATA_WIDTH-1:0] ONE_D    = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ADD, S_PLAY_ON, S_PLAY_OFF, S_WAIT_IN, S_FAIL, S_WIN
    } state_t;

    state_t                state, state_n;
    logic [LW-1:0]         level_n;
    logic [ADDR_WIDTH-1:0] idx, idx_n;
    logic [CW-1:0]         tick_cnt, cnt_n;
    logic                  blink, blink_n;
    logic                  last, btn_match;

    assign mem_r_addr = idx;
    assign mem_w_addr = level[ADDR_WIDTH-1:0];
    assign mem_w_data = ONE_D << rnd;

    // Stored colours are one-hot, but a zero or multi-hot press must never match.
    assign last      = ({1'b0, idx} == (level - ONE_L));
    assign btn_match = (btn == mem_r_data) && (btn != '0)
                     && ((btn & (btn - ONE_D)) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            level    <= '0;
            idx      <= '0;
            tick_cnt <= '0;
            blink    <= 1'b0;
        end else begin
            state    <= state_n;
            level    <= level_n;
            idx      <= idx_n;
            tick_cnt <= cnt_n;
            blink    <= blink_n;
        end
    end

    always_comb begin
        state_n     = state;
        level_n     = level;
        idx_n       = idx;
        cnt_n       = tick_cnt;
        blink_n     = blink;
        led         = '0;
        mem_w_en    = 1'b0;
        busy        = 1'b0;
        await_input = 1'b0;
        game_over   = 1'b0;
        win         = 1'b0;
        case (state)
            S_IDLE, S_FAIL, S_WIN: begin
                if (state == S_FAIL) begin
                    game_over = 1'b1;
                    led       = '1;
                end
                if (state == S_WIN) begin
                    win = 1'b1;
                    led = blink ? '0 : '1;
                    if (tick) blink_n = ~blink;
                end
                if (start) begin
                    level_n = '0;
                    state_n = S_ADD;
                end
            end
            S_ADD: begin
                busy     = 1'b1;
                mem_w_en = 1'b1;
                level_n  = level + ONE_L;
                idx_n    = '0;
                cnt_n    = '0;
                state_n  = S_PLAY_ON;
            end
            S_PLAY_ON: begin
                busy = 1'b1;
                led  = mem_r_data;
                if (tick) begin
                    if (tick_cnt == ON_LAST) begin
                        cnt_n   = '0;
                        state_n = S_PLAY_OFF;
                    end else begin
                        cnt_n = tick_cnt + ONE_C;
                    end
                end
            end
            S_PLAY_OFF: begin
                busy = 1'b1;
                if (tick) begin
                    if (tick_cnt == OFF_LAST) begin
                        cnt_n = '0;
                        if (last) begin
                            idx_n   = '0;
                            state_n = S_WAIT_IN;
                        end else begin
                            idx_n   = idx + ONE_A;
                            state_n = S_PLAY_ON;
                        end
                    end else begin
                        cnt_n = tick_cnt + ONE_C;
                    end
                end
            end
            S_WAIT_IN: begin
                await_input = 1'b1;
                // A press takes priority over a coincident tick and restarts the timeout.
                if (btn_valid) begin
                    led = btn;
                    if (btn_match) begin
                        cnt_n = '0;
                        if (last) begin
                            if (level == LVL_MAX) begin
                                blink_n = 1'b0;
                                state_n = S_WIN;
                            end else begin
                                state_n = S_ADD;
                            end
                        end else begin
                            idx_n = idx + ONE_A;
                        end
                    end else begin
                        state_n = S_FAIL;
                    end
                end else if (tick) begin
                    if (tick_cnt == TO_LAST) begin
                        cnt_n   = '0;
                        state_n = S_FAIL;
                    end else begin
                        cnt_n = tick_cnt + ONE_C;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

endmodule
